serial_add_ctrl: RTL

Bit-serial adder controller that shares one 1-bit full-adder cell across a WIDTH-bit operation. It accepts an operand pair over a valid/ready handshake and steps the cell LSB-first, one bit per clock, through a carry register. It then presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between a small requester (sequencer or register file) and the adder cell, trading WIDTH cycles of latency for a single full-adder's area.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_add_ctrl_fa_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller: the controller
// state encoding and the default operand width.
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Operand/result handshake bundle between a requester and serial_add_ctrl.
//   in_valid/in_ready   : operand pair handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout)
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Single-bit full adder shared by the serial controller.
//   a_i, b_i, cin_i : addend bits and carry-in
//   s_o, cout_o     : sum bit and carry-out
// ---------------------------------------------------------------------------
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder: accepts an operand pair, walks one fa_cell
// LSB-first through a carry register (one bit per clock), then holds the
// sum and carry-out until the consumer takes them.
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : serial_add_ctrl_if.slave (operand and result handshakes)
//   busy_o  : high while an operation is in RUN or DONE
// Optional feature: define SERIAL_ADD_SUB_EN to honour bus.sub (A - B).
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    serial_add_ctrl_if.slave    bus,
    output logic                busy_o
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s_bit;
    logic             c_bit;

    fa_cell u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_o    (s_bit),
        .cout_o (c_bit)
    );

`ifndef SERIAL_ADD_SUB_EN
    logic unused_sub;
    assign unused_sub = bus.sub;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
                    // Two's-complement subtract: A + ~B + 1.
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Result bits enter at the MSB; after WIDTH shifts bit 0 of
                // the operands has landed at sum_q[0].
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                carry_d = c_bit;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
